// File: rtl/bcd_disp_pkg.sv
// Shared constants for the 2-digit BCD scan display: segment patterns
// (active-high, gfedcba order) and digit index values.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic DIG_ONES = 1'b0;
    localparam logic DIG_TENS = 1'b1;
    localparam int   DIGITS   = 2;

    function automatic logic nibble_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

    // Board polarity is applied once, at the output register input.
    function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern; 10..15 show "E".
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_E;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 2-digit 7-segment driver with guard band between digit
// slots, leading-zero blanking and invalid-BCD flag. Outputs are registered.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       err
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [6:0] SEG_INACT = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_INACT = ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             idx_reg, idx_next;
    logic [7:0]       held_reg, held_next;
    logic             err_reg, err_next;
    logic [6:0]       seg_reg, seg_next;
    logic [1:0]       dig_reg, dig_next;

    logic [DIGITS-1:0][6:0] digit_pat;
    logic [DIGITS-1:0]      dig_on;
    logic                   slot_on;
    logic                   wrap;
    logic                   blank;
    logic [6:0]             seg_raw;

    // One decoder per digit; the scan index just selects between them.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            seg7_decode u_dec (
                .nibble  (held_reg[gi*4 +: 4]),
                .pattern (digit_pat[gi])
            );
            assign dig_on[gi] = slot_on && (idx_reg == 1'(gi));
        end
    endgenerate

    assign slot_on = (cnt_reg >= GUARD_C);
    assign wrap    = (cnt_reg == CNT_LAST);
    // An invalid tens nibble is nonzero, so it is never blanked.
    assign blank   = (idx_reg == DIG_TENS) && blank_lz && (held_reg[7:4] == 4'd0);

    always_comb begin
        cnt_next  = cnt_reg + CNT_W'(1);
        idx_next  = idx_reg;
        held_next = held_reg;
        err_next  = err_reg;
        seg_raw   = digit_pat[idx_reg];
        seg_next  = SEG_INACT;
        dig_next  = DIG_INACT;

        if (wrap) begin
            cnt_next = '0;
            idx_next = ~idx_reg;
        end

        if (load) begin
            held_next = bcd_in;
            err_next  = nibble_invalid(bcd_in[7:4]) | nibble_invalid(bcd_in[3:0]);
        end

        if (blank) begin
            seg_raw = SEG_OFF;
        end
        seg_next = seg_polarity(seg_raw, ACTIVE_LOW);
        dig_next = ACTIVE_LOW ? ~dig_on : dig_on;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            idx_reg  <= DIG_ONES;
            held_reg <= 8'h00;
            err_reg  <= 1'b0;
            seg_reg  <= SEG_INACT;
            dig_reg  <= DIG_INACT;
        end else begin
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            held_reg <= held_next;
            err_reg  <= err_next;
            seg_reg  <= seg_next;
            dig_reg  <= dig_next;
        end
    end

    assign seg = seg_reg;
    assign dig = dig_reg;
    assign err = err_reg;

endmodule
